// File: rtl/vmm_result_sink.sv
// vmm_result_sink: consumer end of the VMM result handshake.
// Captures one (value, row, column) result per next_i request and acknowledges it
// with a one-cycle done_o pulse. Results land in an L x M buffer with a valid bit
// per entry. The block tracks the number of distinct filled entries and keeps a
// sticky error flag for out-of-range indices and requests that arrive once the
// buffer is full. A registered random-access read port serves the readout logic.
module vmm_result_sink #(
  parameter int L  = 5,
  parameter int M  = 5,
  parameter int W  = 8,
  parameter int IW = 5
) (
  input  logic          vmm_clk,
  input  logic          rst,
  input  logic          next_i,
  input  logic [W-1:0]  vmm_in,
  input  logic [IW-1:0] i_in,
  input  logic [IW-1:0] j_in,
  output logic          done_o,
  input  logic          clear_i,
  input  logic [IW-1:0] rd_i,
  input  logic [IW-1:0] rd_j,
  output logic [W-1:0]  rd_data,
  output logic [IW:0]   count_o,
  output logic          full_o,
  output logic          err_o,
  output logic [1:0]    state_o
);

  // Buffer geometry. The count is IW+1 bits wide; IW must be chosen so that
  // L*M fits in IW+1 bits.
  localparam int N  = L * M;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0] CAP = (IW+1)'(N);
  localparam logic [IW:0] ONE = (IW+1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2,
    FULL     = 2'd3
  } state_t;

  state_t         state_q;
  logic [W-1:0]   mem [N];
  logic [N-1:0]   valid_q;
  logic [IW:0]    count_q;

  logic           wr_ok;
  logic [AW-1:0]  wr_addr;
  logic           rd_ok;
  logic [AW-1:0]  rd_addr;
  logic           do_write;

  // True when (i, j) addresses an entry inside the L x M buffer.
  function automatic logic idx_ok(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return (int'(i) < L) && (int'(j) < M);
  endfunction

  // Row-major linear address i*M + j; only meaningful when idx_ok holds.
  function automatic logic [AW-1:0] idx_addr(input logic [IW-1:0] i, input logic [IW-1:0] j);
    int a;
    a = int'(i) * M + int'(j);
    return a[AW-1:0];
  endfunction

  // Decode write and read indices; out-of-range indices are parked at address 0
  // so no array access ever leaves the buffer.
  always_comb begin
    wr_ok   = idx_ok(i_in, j_in);
    wr_addr = wr_ok ? idx_addr(i_in, j_in) : '0;
    rd_ok   = idx_ok(rd_i, rd_j);
    rd_addr = rd_ok ? idx_addr(rd_i, rd_j) : '0;
  end

  // A memory write happens only for an in-range request seen in IDLE with no
  // clear or reset on the same edge (clear wins over a colliding capture).
  assign do_write = !rst && !clear_i && next_i && (state_q == IDLE) && wr_ok;

  // Handshake FSM with registered done_o, plus valid bits, fill count and
  // sticky error flag. Clear behaves exactly like reset for this state.
  always_ff @(posedge vmm_clk) begin
    if (rst || clear_i) begin
      state_q <= IDLE;
      done_o  <= 1'b0;
      valid_q <= '0;
      count_q <= '0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (next_i) begin
            if (wr_ok) begin
              // A duplicate index overwrites the value but does not recount.
              if (!valid_q[wr_addr]) begin
                valid_q[wr_addr] <= 1'b1;
                count_q          <= count_q + ONE;
              end
            end else begin
              err_o <= 1'b1;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          done_o  <= 1'b1;
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // Hold here until the VMM releases next_i so one request = one write.
          if (!next_i) begin
            state_q <= (count_q == CAP) ? FULL : IDLE;
          end
        end
        FULL: begin
          // Still acknowledge so the VMM never deadlocks, but flag the drop.
          if (next_i) begin
            err_o   <= 1'b1;
            state_q <= ACK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result storage; data is not reset, stale words are masked by valid bits.
  always_ff @(posedge vmm_clk) begin
    if (do_write) begin
      mem[wr_addr] <= vmm_in;
    end
  end

  // Registered read port: pre-write value on a same-edge write, zero for
  // empty or out-of-range entries.
  always_ff @(posedge vmm_clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= (rd_ok && valid_q[rd_addr]) ? mem[rd_addr] : '0;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CAP);
  assign state_o = 2'(state_q);

endmodule

// File: tb/tb_vmm_result_sink.sv
// Testbench for vmm_result_sink: directed handshake sequences against a
// transaction-level buffer model, with a per-cycle compare process and
// hand-computed literal expectations.
module tb_vmm_result_sink;

  logic       vmm_clk;
  logic       rst;
  logic       next_i;
  logic [7:0] vmm_in;
  logic [4:0] i_in;
  logic [4:0] j_in;
  logic       done_o;
  logic       clear_i;
  logic [4:0] rd_i;
  logic [4:0] rd_j;
  logic [7:0] rd_data;
  logic [5:0] count_o;
  logic       full_o;
  logic       err_o;
  logic [1:0] state_o;

  vmm_result_sink #(.L(5), .M(5), .W(8), .IW(5)) dut (
    .vmm_clk (vmm_clk),
    .rst     (rst),
    .next_i  (next_i),
    .vmm_in  (vmm_in),
    .i_in    (i_in),
    .j_in    (j_in),
    .done_o  (done_o),
    .clear_i (clear_i),
    .rd_i    (rd_i),
    .rd_j    (rd_j),
    .rd_data (rd_data),
    .count_o (count_o),
    .full_o  (full_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  initial vmm_clk = 1'b0;
  always #5 vmm_clk = ~vmm_clk;

  // Behavioural model of the buffer contents and status
  logic [7:0] model_mem [25];
  bit         model_valid [25];
  int         model_count;
  bit         model_err;
  bit         model_done;
  logic [7:0] exp_rd;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  done_cnt = 0;
  bit  chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] ri, input logic [4:0] rj);
    int a;
    if (int'(ri) >= 5 || int'(rj) >= 5) return 8'h00;
    a = int'(ri) * 5 + int'(rj);
    return model_valid[a] ? model_mem[a] : 8'h00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 25; k++) model_valid[k] = 1'b0;
    model_count = 0;
    model_err   = 1'b0;
    model_done  = 1'b0;
  endtask

  task automatic model_capture(input int i, input int j, input logic [7:0] v);
    int a;
    if (model_count == 25) begin
      model_err = 1'b1;
    end else if (i >= 5 || j >= 5) begin
      model_err = 1'b1;
    end else begin
      a = i * 5 + j;
      model_mem[a] = v;
      if (!model_valid[a]) begin
        model_valid[a] = 1'b1;
        model_count++;
      end
    end
  endtask

  // Expected read data follows the address and model state seen at each edge
  always @(posedge vmm_clk) begin
    if (rst) exp_rd <= 8'h00;
    else     exp_rd <= model_read(rd_i, rd_j);
  end

  // Count acknowledge pulses
  always @(negedge vmm_clk) begin
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Per-cycle compare against the model
  always @(negedge vmm_clk) begin
    if (chk_en) begin
      chk("cyc_done",  done_o,  model_done);
      chk("cyc_count", count_o, model_count);
      chk("cyc_full",  full_o,  (model_count == 25));
      chk("cyc_err",   err_o,   model_err);
      chk("cyc_rd",    rd_data, exp_rd);
    end
  end

  task automatic tick();
    @(posedge vmm_clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    model_clear();
    clear_i = 1'b0;
  endtask

  // One complete request: capture edge, ack edge, release edge
  task automatic do_req(input int i, input int j, input logic [7:0] v);
    int d0;
    d0     = done_cnt;
    next_i = 1'b1;
    i_in   = i[4:0];
    j_in   = j[4:0];
    vmm_in = v;
    tick();
    model_capture(i, j, v);
    chk("done_low_at_capture", done_o, 1'b0);
    tick();
    model_done = 1'b1;
    chk("done_high_after_capture", done_o, 1'b1);
    next_i = 1'b0;
    tick();
    model_done = 1'b0;
    chk("done_single_cycle", done_o, 1'b0);
    chk("done_pulse_count", done_cnt - d0, 1);
  endtask

  task automatic read_chk(input string name, input int i, input int j, input logic [7:0] expv);
    rd_i = i[4:0];
    rd_j = j[4:0];
    tick();
    chk(name, rd_data, expv);
  endtask

  initial begin
    int d0;
    rst = 1'b1; next_i = 1'b0; clear_i = 1'b0; vmm_in = 8'h00;
    i_in = 5'd0; j_in = 5'd0; rd_i = 5'd0; rd_j = 5'd0;
    for (int k = 0; k < 25; k++) model_mem[k] = 8'h00;
    model_clear();

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_done",  done_o,  1'b0);
    chk("rst_count", count_o, 6'd0);
    chk("rst_full",  full_o,  1'b0);
    chk("rst_err",   err_o,   1'b0);
    chk("rst_state", state_o, 2'd0);
    chk("rst_rd",    rd_data, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    read_chk("rst_rd00", 0, 0, 8'h00);

    // Single write
    do_req(2, 4, 8'h3C);
    chk("single_count", count_o, 6'd1);
    read_chk("single_rd24", 2, 4, 8'h3C);

    // Duplicate index and out-of-range index
    do_clear();
    do_req(1, 1, 8'h11);
    do_req(1, 1, 8'h22);
    chk("dup_count", count_o, 6'd1);
    read_chk("dup_rd11", 1, 1, 8'h22);
    do_req(5, 0, 8'h55);
    chk("range_err",   err_o,   1'b1);
    chk("range_count", count_o, 6'd1);

    // next_i held high for 10 cycles
    do_clear();
    chk("clear_err", err_o, 1'b0);
    d0 = done_cnt;
    next_i = 1'b1; i_in = 5'd2; j_in = 5'd2; vmm_in = 8'h5A;
    tick();
    model_capture(2, 2, 8'h5A);
    tick();
    model_done = 1'b1;
    tick();
    model_done = 1'b0;
    repeat (7) tick();
    next_i = 1'b0;
    tick();
    tick();
    chk("hold_pulses", done_cnt - d0, 1);
    chk("hold_count",  count_o, 6'd1);
    read_chk("hold_rd22", 2, 2, 8'h5A);

    // Clear colliding with a new request
    do_clear();
    do_req(0, 0, 8'h01);
    do_req(0, 1, 8'h02);
    do_req(0, 2, 8'h03);
    chk("coll_pre_count", count_o, 6'd3);
    clear_i = 1'b1; next_i = 1'b1; i_in = 5'd3; j_in = 5'd3; vmm_in = 8'h33;
    tick();
    model_clear();
    clear_i = 1'b0;
    chk("coll_count0", count_o, 6'd0);
    chk("coll_noack",  done_o,  1'b0);
    tick();
    model_capture(3, 3, 8'h33);
    chk("coll_count1", count_o, 6'd1);
    tick();
    model_done = 1'b1;
    chk("coll_ack", done_o, 1'b1);
    next_i = 1'b0;
    tick();
    model_done = 1'b0;
    read_chk("coll_rd00", 0, 0, 8'h00);
    read_chk("coll_rd01", 0, 1, 8'h00);
    read_chk("coll_rd33", 3, 3, 8'h33);

    // Full fill with value i*16+j
    do_clear();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        do_req(i, j, 8'(i * 16 + j));
    chk("fill_count", count_o, 6'd25);
    chk("fill_full",  full_o,  1'b1);
    chk("fill_state", state_o, 2'd3);
    chk("fill_err",   err_o,   1'b0);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        read_chk("fill_rd", i, j, 8'(i * 16 + j));
    do_req(4, 4, 8'hFF);
    chk("over_err",   err_o,   1'b1);
    chk("over_count", count_o, 6'd25);
    chk("over_state", state_o, 2'd3);
    read_chk("over_rd44", 4, 4, 8'h44);

    // Reset in the middle of a handshake with next_i still high
    do_clear();
    chk("clr_from_full_state", state_o, 2'd0);
    next_i = 1'b1; i_in = 5'd4; j_in = 5'd4; vmm_in = 8'h44;
    tick();
    model_capture(4, 4, 8'h44);
    rst = 1'b1;
    tick();
    model_clear();
    rst = 1'b0;
    chk("rstmid_done", done_o,  1'b0);
    chk("rstmid_count", count_o, 6'd0);
    tick();
    model_capture(4, 4, 8'h44);
    chk("rstmid_recapture", count_o, 6'd1);
    tick();
    model_done = 1'b1;
    chk("rstmid_ack", done_o, 1'b1);
    next_i = 1'b0;
    tick();
    model_done = 1'b0;
    read_chk("rstmid_rd44", 4, 4, 8'h44);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
